// File: rtl/imm_instr_encoder_pkg.sv
// Shared immediate-class constants, field limits and the check->assemble bundle.
// Used by imm_instr_encoder, imm_range_check and the immediate extender.
package imm_instr_encoder_pkg;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;

  // Only imm[20:0] is ever placed in an instruction word.
  typedef struct packed {
    logic [1:0]  src;
    logic [20:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  opcode;
    logic        err;
  } s1_t;

endpackage

// File: rtl/imm_range_check.sv
// Combinational range/alignment check of an immediate for its class.
// Ports: ImmSrc, Imm in; err out (1 = does not fit or misaligned).
module imm_range_check
  import imm_instr_encoder_pkg::*;
(
  input  logic [1:0]  ImmSrc,
  input  logic [31:0] Imm,
  output logic        err
);

  logic signed [31:0] v;
  assign v = $signed(Imm);

  always_comb begin
    err = 1'b0;
    unique case (ImmSrc)
      IMM_I, IMM_S:
        err = (v < IMM12_MIN) || (v > IMM12_MAX);
      IMM_B:
        err = (v < IMM13_MIN) || (v > IMM13_MAX) || Imm[0];
      IMM_J:
        err = (v < IMM21_MIN) || (v > IMM21_MAX) || Imm[0];
    endcase
  end

endmodule

// File: rtl/imm_instr_encoder.sv
// Two-stage valid/ready encoder: range check, then I/S/B/J bit assembly.
// Ports: clk, reset_n, in_valid/in_ready + fields in; out_valid/out_ready, Instr, range_err, err_count.
module imm_instr_encoder
  import imm_instr_encoder_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           ImmSrc,
  input  logic [31:0]          Imm,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [2:0]           funct3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          Instr,
  output logic                 range_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  s1_t         s1_q;
  logic        s1_valid;
  logic        err_d;
  logic        s2_ready;
  logic [31:0] instr_d;

  imm_range_check u_chk (
    .ImmSrc (ImmSrc),
    .Imm    (Imm),
    .err    (err_d)
  );

  // S2 frees when empty or draining; S1 frees whenever S2 can take its beat.
  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q.src    <= ImmSrc;
        s1_q.imm    <= Imm[20:0];
        s1_q.rd     <= rd;
        s1_q.rs1    <= rs1;
        s1_q.rs2    <= rs2;
        s1_q.funct3 <= funct3;
        s1_q.opcode <= opcode;
        s1_q.err    <= err_d;
      end
    end
  end

  always_comb begin
    instr_d = '0;
    unique case (s1_q.src)
      IMM_I:
        instr_d = {s1_q.imm[11:0], s1_q.rs1,
                   s1_q.funct3, s1_q.rd, s1_q.opcode};
      IMM_S:
        instr_d = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1,
                   s1_q.funct3, s1_q.imm[4:0], s1_q.opcode};
      IMM_B:
        instr_d = {s1_q.imm[12], s1_q.imm[10:5],
                   s1_q.rs2, s1_q.rs1, s1_q.funct3,
                   s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
      IMM_J:
        instr_d = {s1_q.imm[20], s1_q.imm[10:1],
                   s1_q.imm[11], s1_q.imm[19:12],
                   s1_q.rd, s1_q.opcode};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      Instr     <= '0;
      range_err <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Instr     <= instr_d;
        range_err <= s1_q.err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (out_valid && out_ready && range_err &&
                 (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Self-checking bench for imm_instr_encoder: directed vectors plus a
// randomized scoreboard stream with a behavioural encoding model.
module tb_imm_instr_encoder;

  typedef struct {
    logic [1:0] src;
    int         imm;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] f3;
    logic [6:0] op;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ImmSrc;
  logic [31:0] Imm;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Instr;
  logic        range_err;
  logic [7:0]  err_count;

  int    total = 0;
  int    bad = 0;
  int    model_cnt = 0;
  beat_t q[$];

  always #5 clk = ~clk;

  imm_instr_encoder #(.ERR_CNT_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ImmSrc    (ImmSrc),
    .Imm       (Imm),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Instr     (Instr),
    .range_err (range_err),
    .err_count (err_count)
  );

  function automatic int lim_of(logic [1:0] src);
    if (src < 2) return 2048;
    if (src == 2) return 4096;
    return 1048576;
  endfunction

  // Returns {err, instr}
  function automatic logic [32:0] ref_enc(beat_t b);
    logic [31:0] u;
    logic [31:0] w;
    int          lim;
    logic        e;
    u   = b.imm;
    lim = lim_of(b.src);
    e   = (b.imm < -lim) || (b.imm >= lim) ||
          (b.src >= 2 && (b.imm % 2) != 0);
    case (b.src)
      2'd0: w = {u[11:0], b.rs1, b.f3, b.rd, b.op};
      2'd1: w = {u[11:5], b.rs2, b.rs1, b.f3, u[4:0], b.op};
      2'd2: w = {u[12], u[10:5], b.rs2, b.rs1, b.f3,
                 u[4:1], u[11], b.op};
      default: w = {u[20], u[10:1], u[11], u[19:12], b.rd, b.op};
    endcase
    return {e, w};
  endfunction

  function automatic beat_t mk(logic [1:0] s, int imm,
                               logic [4:0] d, logic [4:0] r1,
                               logic [4:0] r2, logic [2:0] f,
                               logic [6:0] o);
    beat_t b;
    b.src = s; b.imm = imm; b.rd = d; b.rs1 = r1;
    b.rs2 = r2; b.f3 = f; b.op = o;
    return b;
  endfunction

  function automatic beat_t rand_beat(int mode);
    beat_t b;
    int    lim;
    int    pick[6];
    b.src = 2'($urandom_range(3));
    b.rd  = 5'($urandom); b.rs1 = 5'($urandom);
    b.rs2 = 5'($urandom); b.f3  = 3'($urandom);
    b.op  = 7'($urandom);
    lim   = lim_of(b.src);
    pick  = '{-lim, lim - 1, -lim - 1, lim, lim - 2, 1};
    if (mode == 1) begin
      b.imm = lim + int'($urandom_range(1000));
    end else begin
      case ($urandom_range(3))
        0: b.imm = int'($urandom_range(2 * lim - 1)) - lim;
        1: b.imm = pick[$urandom_range(5)];
        2: b.imm = int'($urandom);
        default: b.imm = int'($urandom_range(16)) - 8;
      endcase
    end
    return b;
  endfunction

  task automatic drive(beat_t b);
    ImmSrc = b.src; Imm = b.imm; rd = b.rd; rs1 = b.rs1;
    rs2 = b.rs2; funct3 = b.f3; opcode = b.op;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    model_cnt = 0;
    q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || Instr !== 32'h0 ||
        range_err !== 1'b0 || err_count !== 8'h0 ||
        in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset: ov=%b instr=%h re=%b cnt=%0d ir=%b, want 0 0 0 0 1",
               out_valid, Instr, range_err, err_count, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_vectors();
    beat_t       v[4];
    logic [31:0] exp_i[4];
    exp_i = '{32'h01000093, 32'h00202423, 32'hFE000EE3, 32'h001000EF};
    v[0] = mk(2'd0, 16, 5'd1, 5'd0, 5'($urandom), 3'd0, 7'h13);
    v[1] = mk(2'd1, 8, 5'($urandom), 5'd0, 5'd2, 3'd2, 7'h23);
    v[2] = mk(2'd2, -4, 5'($urandom), 5'd0, 5'd0, 3'd0, 7'h63);
    v[3] = mk(2'd3, 2048, 5'd1, 5'($urandom), 5'($urandom),
              3'($urandom), 7'h6F);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(v[i]); in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL latency%0d: out_valid=%b one cycle after accept, want 0",
                 i, out_valid);
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || Instr !== exp_i[i] || range_err !== 1'b0) begin
        bad++;
        $display("FAIL vector%0d: ov=%b instr=%h re=%b, want 1 %h 0",
                 i, out_valid, Instr, range_err, exp_i[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_errors();
    beat_t       v[6];
    logic        e_exp[6];
    logic [32:0] r;
    int          cnt;
    cnt = 0;
    v[0] = mk(2'd0, 2048, 5'd3, 5'd4, 5'd0, 3'd0, 7'h13);
    v[1] = mk(2'd2, 5, 5'd0, 5'd1, 5'd2, 3'd1, 7'h63);
    v[2] = mk(2'd1, -2048, 5'd0, 5'd7, 5'd8, 3'd2, 7'h23);
    v[3] = mk(2'd2, 4094, 5'd0, 5'd9, 5'd10, 3'd5, 7'h63);
    v[4] = mk(2'd3, -1048578, 5'd11, 5'd0, 5'd0, 3'd0, 7'h6F);
    v[5] = mk(2'd3, -1048576, 5'd12, 5'd0, 5'd0, 3'd0, 7'h6F);
    e_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      r = ref_enc(v[i]);
      @(negedge clk);
      drive(v[i]); in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || range_err !== e_exp[i] ||
          Instr !== r[31:0]) begin
        bad++;
        $display("FAIL err_vec%0d: ov=%b re=%b instr=%h, want 1 %b %h",
                 i, out_valid, range_err, Instr, e_exp[i], r[31:0]);
      end
      @(posedge clk); #1;
      if (e_exp[i]) cnt++;
      total++;
      if (err_count !== 8'(cnt)) begin
        bad++;
        $display("FAIL err_count%0d: got %0d want %0d", i, err_count, cnt);
      end
    end
    model_cnt = cnt;
  endtask

  task automatic stream(input int n, input int rdy_pct,
                        input int vld_pct, input int mode,
                        input string name, output int cycles);
    int          sent;
    logic        have;
    beat_t       cur;
    beat_t       eb;
    logic [32:0] r;
    sent = 0; have = 1'b0; cycles = 0;
    while ((sent < n || q.size() > 0) && cycles < 20000) begin
      @(negedge clk);
      if (!have && sent < n && int'($urandom_range(99)) < vld_pct) begin
        cur = rand_beat(mode); have = 1'b1;
      end
      in_valid = have;
      if (have) drive(cur);
      out_ready = int'($urandom_range(99)) < rdy_pct;
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL %s_extra: unexpected beat instr=%h", name, Instr);
        end else begin
          eb = q.pop_front();
          r = ref_enc(eb);
          if (Instr !== r[31:0] || range_err !== r[32]) begin
            bad++;
            $display("FAIL %s_data: instr=%h re=%b, want %h %b",
                     name, Instr, range_err, r[31:0], r[32]);
          end
          if (r[32] && model_cnt < 255) model_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(cur); have = 1'b0; sent++;
      end
      @(posedge clk);
      cycles++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (cycles >= 20000) begin
      bad++;
      $display("FAIL %s_timeout: %0d beats left", name, q.size());
    end
    total++;
    if (err_count !== 8'(model_cnt)) begin
      bad++;
      $display("FAIL %s_count: err_count=%0d want %0d",
               name, err_count, model_cnt);
    end
  endtask

  task automatic test_random();
    int c;
    stream(400, 60, 70, 0, "random", c);
  endtask

  task automatic test_back_to_back();
    int c;
    stream(50, 100, 100, 0, "b2b", c);
    total++;
    if (c !== 52) begin
      bad++;
      $display("FAIL b2b_rate: %0d cycles for 50 beats, want 52", c);
    end
  endtask

  task automatic test_saturation();
    int c;
    stream(300, 100, 100, 1, "sat", c);
    total++;
    if (err_count !== 8'd255) begin
      bad++;
      $display("FAIL sat_hold: err_count=%0d want 255", err_count);
    end
  endtask

  task automatic test_backpressure();
    beat_t       b[4];
    beat_t       eb;
    logic [32:0] r;
    logic [31:0] held;
    logic        seen;
    int          idx;
    int          got;
    int          cyc;
    for (int i = 0; i < 4; i++) b[i] = rand_beat(0);
    idx = 0; got = 0; seen = 1'b0; held = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; drive(b[idx]); out_ready = 1'b0;
      #1;
      if (seen) begin
        total++;
        if (out_valid !== 1'b1 || Instr !== held) begin
          bad++;
          $display("FAIL bp_stable: ov=%b instr=%h, want 1 %h",
                   out_valid, Instr, held);
        end
      end else if (out_valid) begin
        seen = 1'b1; held = Instr;
      end
      if (in_ready) begin
        q.push_back(b[idx]); idx++;
      end
      @(posedge clk);
    end
    #1;
    total++;
    if (idx !== 2 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_accepts: accepted=%0d in_ready=%b, want 2 0",
               idx, in_ready);
    end
    cyc = 0;
    while ((idx < 4 || q.size() > 0) && cyc < 100) begin
      @(negedge clk);
      in_valid = idx < 4;
      if (idx < 4) drive(b[idx]);
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL bp_dup: extra beat instr=%h", Instr);
        end else begin
          eb = q.pop_front(); r = ref_enc(eb); got++;
          if (Instr !== r[31:0] || range_err !== r[32]) begin
            bad++;
            $display("FAIL bp_order: instr=%h re=%b, want %h %b",
                     Instr, range_err, r[31:0], r[32]);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(b[idx]); idx++;
      end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (got !== 4 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: got=%0d ov=%b, want 4 0", got, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    beat_t b;
    int    emitted;
    emitted = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      b = rand_beat(1); drive(b);
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) emitted++;
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    total++;
    if (err_count !== 8'(emitted) || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: err_count=%0d ov=%b, want %0d 1",
               err_count, out_valid, emitted);
    end
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || err_count !== 8'h0 || range_err !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: ov=%b cnt=%0d re=%b, want 0 0 0",
               out_valid, err_count, range_err);
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_drop: ov=%b after reset, want 0", out_valid);
    end
    model_cnt = 0;
    q.delete();
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ImmSrc = '0; Imm = '0; opcode = '0; rd = '0;
    rs1 = '0; rs2 = '0; funct3 = '0;
    test_reset();
    test_vectors();
    do_reset();
    test_errors();
    test_random();
    test_back_to_back();
    do_reset();
    test_saturation();
    do_reset();
    test_backpressure();
    do_reset();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
